// File: rtl/slow_fpu_scoreboard_if.sv
// Decode/slow-FPU handshake bundle for slow_fpu_scoreboard.
//   slave  : seen by the scoreboard (decode + sfpu_done in; stall/launch/writeback out)
//   master : seen by the pipeline / bench that drives decode and the slow FPU
interface slow_fpu_scoreboard_if #(
  parameter int REG_W = 5
);
  logic             id_valid;
  logic             id_slow_dispatch;
  logic             id_fast_dispatch;
  logic             id_fpu_reg_write;
  logic [REG_W-1:0] id_rd;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [REG_W-1:0] id_rs3;
  logic [2:0]       id_rs_en;
  logic             id_kill;
  logic             sfpu_done;
  logic             stall;
  logic             sfpu_start;
  logic             wb_slow_sel;
  logic [REG_W-1:0] wb_rd;
  logic             sfpu_pending;
  logic             err_timeout;

  modport master (
    output id_valid, id_slow_dispatch, id_fast_dispatch, id_fpu_reg_write,
           id_rd, id_rs1, id_rs2, id_rs3, id_rs_en, id_kill, sfpu_done,
    input  stall, sfpu_start, wb_slow_sel, wb_rd, sfpu_pending, err_timeout
  );

  modport slave (
    input  id_valid, id_slow_dispatch, id_fast_dispatch, id_fpu_reg_write,
           id_rd, id_rs1, id_rs2, id_rs3, id_rs_en, id_kill, sfpu_done,
    output stall, sfpu_start, wb_slow_sel, wb_rd, sfpu_pending, err_timeout
  );
endinterface

// File: rtl/slow_fpu_scoreboard.sv
// Single-entry scoreboard for a slow (multi-cycle) FPU. Tracks one in-flight
// slow op, stalls decode on structural/RAW/WAW/write-port hazards against it,
// grants the FP write port for one cycle when the result returns, and flags a
// sticky timeout if the FPU takes too long.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slow_fpu_scoreboard_if.slave (decode inputs, sfpu_done in;
//              stall, sfpu_start, wb_slow_sel, wb_rd, sfpu_pending, err_timeout out)
module slow_fpu_scoreboard #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst,
  slow_fpu_scoreboard_if.slave bus
);
  localparam int                 CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

  state_t           r_state, w_state_nxt;
  logic [REG_W-1:0] r_pending_rd;
  logic [REG_W-1:0] r_wb_rd;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_wb_sel, r_pending, r_err;
  logic             w_err_set, w_raw, w_waw, w_port, w_stall, w_accept;

  // Hazards against the single in-flight destination; register 0 is ordinary.
  always_comb begin
    w_raw   = (bus.id_rs_en[0] && (bus.id_rs1 == r_pending_rd)) ||
              (bus.id_rs_en[1] && (bus.id_rs2 == r_pending_rd)) ||
              (bus.id_rs_en[2] && (bus.id_rs3 == r_pending_rd));
    w_waw   = bus.id_fpu_reg_write && (bus.id_rd == r_pending_rd);
    // The slow result owns the write port during WB.
    w_port  = (r_state == WB) && bus.id_fast_dispatch && bus.id_fpu_reg_write;
    // kill intentionally not an input here: stall must be kill-independent.
    w_stall = !rst && (r_state != IDLE) && bus.id_valid &&
              (bus.id_slow_dispatch || w_raw || w_waw || w_port);
    w_accept = !rst && (r_state == IDLE) && bus.id_valid &&
               bus.id_slow_dispatch && !bus.id_kill && !w_stall;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        w_state_nxt = BUSY;
        w_cnt_nxt   = '0;
      end
      BUSY: if (bus.sfpu_done) begin
        w_state_nxt = WB;
      end else begin
        if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
        // Flag on the edge where the count lands on TIMEOUT.
        w_err_set = (w_cnt_nxt == CNT_MAX);
      end
      WB:      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pending_rd <= '0;
      r_cnt        <= '0;
      r_wb_sel     <= 1'b0;
      r_wb_rd      <= '0;
      r_pending    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_accept) r_pending_rd <= bus.id_rd;
      // Writeback outputs registered from the next state so they line up with WB.
      r_wb_sel  <= (w_state_nxt == WB);
      r_wb_rd   <= (w_state_nxt == WB) ? r_pending_rd : '0;
      r_pending <= (w_state_nxt != IDLE);
      r_err     <= r_err | w_err_set;
    end
  end

  assign bus.stall        = w_stall;
  assign bus.sfpu_start   = w_accept;
  assign bus.wb_slow_sel  = r_wb_sel;
  assign bus.wb_rd        = r_wb_rd;
  assign bus.sfpu_pending = r_pending;
  assign bus.err_timeout  = r_err;
endmodule

// File: tb/tb_slow_fpu_scoreboard.sv
module tb_slow_fpu_scoreboard;
  localparam int REG_W   = 5;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slow_fpu_scoreboard_if #(.REG_W(REG_W)) bus ();
  slow_fpu_scoreboard #(.REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [REG_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    bus.id_valid = 0; bus.id_slow_dispatch = 0; bus.id_fast_dispatch = 0;
    bus.id_fpu_reg_write = 0; bus.id_rd = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_rs3 = '0; bus.id_rs_en = '0; bus.id_kill = 0; bus.sfpu_done = 0;
  endtask

  // Start of a cycle: move away from the rising edge and clear decode.
  task automatic nxt();
    @(negedge clk);
    clr_in();
  endtask

  task automatic slow_op(input logic [REG_W-1:0] rd);
    bus.id_valid = 1; bus.id_slow_dispatch = 1; bus.id_fpu_reg_write = 1; bus.id_rd = rd;
  endtask

  task automatic fast_op(input logic wr, input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1,
                         input logic [REG_W-1:0] rs2, input logic [REG_W-1:0] rs3, input logic [2:0] en);
    bus.id_valid = 1; bus.id_fast_dispatch = 1; bus.id_fpu_reg_write = wr; bus.id_rd = rd;
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rs3 = rs3; bus.id_rs_en = en;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_in();
    rst = 1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // Accept cycle of a slow op: launch expected, destination goes to the scoreboard.
  task automatic accept(input string tag, input logic [REG_W-1:0] rd);
    slow_op(rd);
    #1;
    chk({tag, "_start"}, bus.sfpu_start, 1);
    chk({tag, "_stall"}, bus.stall, 0);
    exp_q.push_back(rd);
  endtask

  task automatic wb_check(input string tag);
    logic [REG_W-1:0] e;
    chk({tag, "_wbsel"}, bus.wb_slow_sel, 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_qempty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_wbrd"}, bus.wb_rd, e);
    end
  endtask

  initial begin
    rst = 1;
    clr_in();
    // Reset state, with a slow op in decode: nothing may launch or stall.
    @(negedge clk);
    slow_op(5'd5);
    #1;
    chk("rst_start", bus.sfpu_start, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_wbsel", bus.wb_slow_sel, 0);
    chk("rst_wbrd", bus.wb_rd, 0);
    chk("rst_pend", bus.sfpu_pending, 0);
    chk("rst_err", bus.err_timeout, 0);
    @(negedge clk);
    clr_in();
    rst = 0;

    // ---- A: fdiv rd=5, done in cycle 10, WB in cycle 11; hazards while BUSY ----
    accept("A0", 5'd5);
    chk("A0_pend", bus.sfpu_pending, 0);
    for (int c = 1; c <= 10; c++) begin
      nxt();
      case (c)
        3: fast_op(1, 5'd8, 5'd1, 5'd5, 5'd0, 3'b010);   // RAW on rs2
        4: fast_op(1, 5'd8, 5'd1, 5'd6, 5'd0, 3'b010);   // no hazard
        6: fast_op(1, 5'd5, 5'd1, 5'd2, 5'd0, 3'b011);   // WAW
        7: fast_op(1, 5'd8, 5'd1, 5'd2, 5'd5, 3'b100);   // RAW on rs3
        8: fast_op(1, 5'd8, 5'd1, 5'd2, 5'd5, 3'b011);   // rs3 not read
        9: begin slow_op(5'd9); bus.id_kill = 1; end     // structural, kill irrelevant
        10: bus.sfpu_done = 1;
        default: ;
      endcase
      #1;
      chk($sformatf("A%0d_pend", c), bus.sfpu_pending, 1);
      chk($sformatf("A%0d_start", c), bus.sfpu_start, 0);
      chk($sformatf("A%0d_wbsel", c), bus.wb_slow_sel, 0);
      case (c)
        3: chk("A3_raw_rs2", bus.stall, 1);
        4: chk("A4_no_haz", bus.stall, 0);
        6: chk("A6_waw", bus.stall, 1);
        7: chk("A7_raw_rs3", bus.stall, 1);
        8: chk("A8_rs3_off", bus.stall, 0);
        9: chk("A9_struct_kill", bus.stall, 1);
        default: ;
      endcase
    end
    nxt();
    fast_op(1, 5'd7, 5'd1, 5'd2, 5'd0, 3'b011);           // fmul f7 in WB
    #1;
    wb_check("A11");
    chk("A11_pend", bus.sfpu_pending, 1);
    chk("A11_port_stall", bus.stall, 1);
    nxt();
    fast_op(1, 5'd7, 5'd1, 5'd2, 5'd0, 3'b011);
    #1;
    chk("A12_wbsel", bus.wb_slow_sel, 0);
    chk("A12_pend", bus.sfpu_pending, 0);
    chk("A12_stall", bus.stall, 0);
    chk("A12_err_sticky", bus.err_timeout, 1);

    // ---- B: back-to-back slow ops, register 0 hazards, kill/done in IDLE ----
    do_reset();
    accept("B0", 5'd0);
    nxt(); fast_op(0, 5'd0, 5'd0, 5'd3, 5'd0, 3'b001); #1;
    chk("B1_raw_f0", bus.stall, 1);
    nxt(); slow_op(5'd9); bus.sfpu_done = 1; #1;
    chk("B2_stall", bus.stall, 1);
    chk("B2_start", bus.sfpu_start, 0);
    nxt(); slow_op(5'd9); #1;
    wb_check("B3");
    chk("B3_stall", bus.stall, 1);
    chk("B3_start", bus.sfpu_start, 0);
    nxt();
    accept("B4", 5'd9);
    chk("B4_wbsel", bus.wb_slow_sel, 0);
    nxt(); fast_op(0, 5'd0, 5'd9, 5'd0, 5'd0, 3'b001); #1;
    chk("B5_raw_new_rd", bus.stall, 1);
    nxt(); fast_op(0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b001); bus.sfpu_done = 1; #1;
    chk("B6_old_rd_free", bus.stall, 0);
    nxt(); #1;
    wb_check("B7");
    nxt(); slow_op(5'd4); bus.id_kill = 1; #1;
    chk("B8_kill_start", bus.sfpu_start, 0);
    nxt(); bus.sfpu_done = 1; #1;
    chk("B9_pend", bus.sfpu_pending, 0);
    nxt(); #1;
    chk("B10_idle_done_wbsel", bus.wb_slow_sel, 0);
    chk("B10_pend", bus.sfpu_pending, 0);

    // ---- C: timeout, TIMEOUT=4: err rises 5 cycles after accept, sticky ----
    do_reset();
    accept("C0", 5'd3);
    for (int c = 1; c <= 8; c++) begin
      nxt();
      if (c == 8) bus.sfpu_done = 1;
      #1;
      chk($sformatf("C%0d_err", c), bus.err_timeout, (c >= 5) ? 1 : 0);
      chk($sformatf("C%0d_pend", c), bus.sfpu_pending, 1);
    end
    nxt(); #1;
    wb_check("C9");
    chk("C9_err", bus.err_timeout, 1);
    nxt(); #1;
    chk("C10_err", bus.err_timeout, 1);
    chk("C10_pend", bus.sfpu_pending, 0);

    // ---- D: reset mid-BUSY takes effect immediately; later done ignored ----
    do_reset();
    accept("D0", 5'd12);
    nxt(); nxt();
    nxt();
    slow_op(5'd6);
    #1;
    chk("D3_busy_stall", bus.stall, 1);
    rst = 1;
    exp_q.delete();
    #1;
    chk("D3_rst_pend", bus.sfpu_pending, 0);
    chk("D3_rst_stall", bus.stall, 0);
    chk("D3_rst_start", bus.sfpu_start, 0);
    chk("D3_rst_err", bus.err_timeout, 0);
    nxt();
    rst = 0;
    bus.sfpu_done = 1;
    #1;
    chk("D4_pend", bus.sfpu_pending, 0);
    nxt(); #1;
    chk("D5_wbsel", bus.wb_slow_sel, 0);
    chk("D5_wbrd", bus.wb_rd, 0);
    chk("D5_pend", bus.sfpu_pending, 0);
    chk("D5_err", bus.err_timeout, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
